// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    XFER,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam int PS2_FRAME_BITS  = 11;
  localparam int PS2_BITCNT_W    = $clog2(PS2_FRAME_BITS);
  localparam int PS2_INHIBIT_50M = 5000;
  localparam int PS2_TIMEOUT_50M = 750000;
  localparam int PS2_CNT_W       = 20;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for one PS/2 line, with a falling-edge pulse.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic fe_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fe_o    = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, start, 8 data bits LSB first,
// odd parity, stop, then checks the device acknowledge.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_50M,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_50M,
  parameter int CNT_W          = PS2_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PS2_BITCNT_W-1:0] PAR_FE  = PS2_BITCNT_W'(8);
  localparam logic [PS2_BITCNT_W-1:0] DATA_FE = PS2_BITCNT_W'(8);

  logic clk_s, clk_fe;
  logic data_s, data_fe_unused;

  ps2_sync_edge u_sync_clk (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (ps2_clk_in),
    .level_o(clk_s),
    .fe_o   (clk_fe)
  );

  ps2_sync_edge u_sync_data (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (ps2_data_in),
    .level_o(data_s),
    .fe_o   (data_fe_unused)
  );

  ps2_state_e              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [PS2_BITCNT_W-1:0] bitcnt_q;
  logic [7:0]              shreg_q;
  logic                    par_q;
  logic                    clk_oe_q;
  logic                    data_oe_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    ack_err_q;
  logic                    timeout_q;

  // Handshake: tx_start is a one-cycle request accepted only while busy=0;
  // busy drops on the same cycle as the done/ack_err/timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_start) begin
            shreg_q  <= tx_data;
            par_q    <= odd_parity(tx_data);
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            clk_oe_q <= 1'b1;
            state_q  <= INHIBIT;
          end
        end
        INHIBIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == INH_PRE) data_oe_q <= 1'b1;
          if (cnt_q == INH_LAST) begin
            clk_oe_q <= 1'b0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            state_q  <= XFER;
          end
        end
        XFER, ACK, WAIT_IDLE: begin
          cnt_q <= cnt_q + 1'b1;
          // Timeout wins over a clock edge arriving on the same cycle.
          if (cnt_q == TO_LAST) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (state_q == XFER) begin
            if (clk_fe) begin
              bitcnt_q <= bitcnt_q + 1'b1;
              if (bitcnt_q < DATA_FE) begin
                data_oe_q <= ~shreg_q[0];
                shreg_q   <= {1'b0, shreg_q[7:1]};
              end else if (bitcnt_q == PAR_FE) begin
                data_oe_q <= ~par_q;
              end else begin
                data_oe_q <= 1'b0;
                state_q   <= ACK;
              end
            end
          end else if (state_q == ACK) begin
            if (clk_fe) begin
              if (!data_s) begin
                state_q <= WAIT_IDLE;
              end else begin
                ack_err_q <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= IDLE;
              end
            end
          end else begin
            if (clk_s && data_s) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Transmits one host-to-device byte on the PS/2 bus, such as keyboard LED command 0xED or reset 0xFF. It is the outbound counterpart of the scan-code receive path that feeds the display shift register.
- Drives the open-collector PS/2 clock and data lines through active-high output enables.
- Frames the byte as start bit, 8 data bits LSB first, odd parity and stop bit.
- Checks the device acknowledge and reports done, ack error or timeout.

Parameters:
INHIBIT_CYCLES, 5000, number of clk cycles ps2_clk is held low before the start bit (100 us at 50 MHz); must be at least 2.
TIMEOUT_CYCLES, 750000, maximum clk cycles from clock release to completion (15 ms at 50 MHz).
CNT_W, 20, width of the shared cycle counter; must satisfy 2^CNT_W > max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tx_data  in  8  byte to send; sampled on the accepted tx_start cycle
tx_start  in  1  single-cycle request; ignored while busy=1
ps2_clk_in  in  1  raw PS/2 clock pin value (asynchronous)
ps2_data_in  in  1  raw PS/2 data pin value (asynchronous)
ps2_clk_oe  out  1  1 = pull PS/2 clock low, 0 = release
ps2_data_oe  out  1  1 = pull PS/2 data low, 0 = release
busy  out  1  high from the accepted start until the cycle the done/ack_err/timeout pulse is asserted
done  out  1  one-cycle pulse: byte sent and device acknowledged
ack_err  out  1  one-cycle pulse: device failed to pull data low on the ack clock
timeout  out  1  one-cycle pulse: transfer aborted by the timeout

Behaviour:
- Reset is asynchronous and active-high; one clock, clk. While rst=1: all outputs 0, both lines released, FSM in IDLE, counters cleared.
- ps2_clk_in and ps2_data_in pass through a 2-FF synchroniser. A falling edge (fe) is previous synced clk=1 and current=0, giving 3-cycle latency from the pin.
- IDLE: on tx_start, latch tx_data into shreg, compute par = ~^tx_data (odd parity), set busy=1, clear cnt, go to INHIBIT.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles. On the final cycle set data_oe=1 (start bit). Next cycle clk_oe=0, cnt cleared, bitcnt=0, go to XFER.
- XFER: on each fe, bitcnt increments:
  - fe 1..8: data_oe = ~shreg[bitcnt-1], so a 0 bit pulls low and a 1 bit releases.
  - fe 9: data_oe = ~par.
  - fe 10: data_oe=0 (stop bit released); go to ACK.
- ACK: on the next fe, sample synced data. Low means acknowledged: go to WAIT_IDLE. High means pulse ack_err, go to IDLE.
- WAIT_IDLE: when synced clk=1 and synced data=1, pulse done, go to IDLE.
- Timeout: cnt runs in XFER, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES: both oe=0, pulse timeout, go to IDLE. The timeout check has priority over an fe in the same cycle.
- busy falls in the same cycle as the done/ack_err/timeout pulse, so a new tx_start is accepted the following cycle.
- tx_start while busy is dropped silently; tx_data changes after acceptance have no effect.
- Reset mid-transfer releases both lines immediately (asynchronously).
- ps2_clk_oe and ps2_data_oe are registered, with no glitches and never driven together except during the inhibit-to-start handoff cycle.

Decomposition:
- Package ps2_pkg holds:
  - the state enum: IDLE, INHIBIT, XFER, ACK, WAIT_IDLE;
  - constant PS2_FRAME_BITS = 11;
  - default timing constants for 50 MHz.
- One sub-module, ps2_sync_edge: 2-FF synchroniser plus falling-edge pulse for one line. Instantiated for clk (with fe) and for data (level only). The receive path reuses it.

Test Plan:
All tests use INHIBIT_CYCLES=20 and TIMEOUT_CYCLES=2000. A bus model generates the device clock at a 40-cycle period and samples data on rising edges.
- Send 0xED:
  - clk_oe high for exactly 20 cycles with data_oe rising on the last of them; then clk_oe=0.
  - Device captures start=0, bits 1,0,1,1,0,1,1,1, parity=1, stop=1.
  - Model acks low, then done pulses once and busy=0.
- Send 0x01, 0x00 and 0xFF back-to-back, each tx_start on the cycle after the prior done -> captured parity 0, 1, 1; three done pulses; no start dropped.
- Model never acks (data stays high on the 11th fe) -> ack_err pulses once, done stays 0, both oe=0, busy=0.
- Model stops clocking after 4 bits -> timeout pulses 2000 cycles after clock release, both lines released, next tx_start accepted.
- tx_start pulsed with 0x55 at cycle 5 of INHIBIT -> ignored; only the original byte is transmitted and a single done appears.
- Assert rst in XFER after 5 bits -> both oe=0 and busy=0 asynchronously. After deassert, a fresh 0xF4 send completes with done.
